// File: rtl/bmp_stream_out.sv
// BMP frame-buffer read-back: validates the header, then streams bytes 0..size-1 over valid/ready.
// Optional macro BMP_SIG_CHECK_EN also requires the 'BM' signature in bytes 0 and 1.
module bmp_stream_out #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int MAX_SIZE   = 786486,
  parameter int MIN_SIZE   = 54
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  RAM_rd_en,
  output logic [ADDR_WIDTH-1:0] RAM_rd_addr,
  input  logic [BYTE_WIDTH-1:0] RAM_Q,
  output logic                  out_valid,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, HDR, STREAM, FIN} state_t;

  state_t                state;
  logic [2:0]            hcnt, dcnt;
  logic [23:0]           size_lo;
  logic [31:0]           hdr_size;
  logic                  hdr_ok;
  logic [ADDR_WIDTH-1:0] raddr, last_addr, byte_cnt;
  logic                  rd_done, inflight;
  logic [BYTE_WIDTH-1:0] fifo_data [2];
  logic                  wp, rp;
  logic [1:0]            cnt, occ;
  logic                  hdr_issue, issue, push, pop;
`ifdef BMP_SIG_CHECK_EN
  logic [7:0]            sig0, sig1;
`endif

  // The sixth header byte is evaluated straight off RAM_Q as it arrives.
  assign hdr_size = {RAM_Q[7:0], size_lo};
  always_comb begin
    hdr_ok = (hdr_size >= 32'(MIN_SIZE)) && (hdr_size <= 32'(MAX_SIZE));
`ifdef BMP_SIG_CHECK_EN
    if (sig0 != 8'h42 || sig1 != 8'h4D) hdr_ok = 1'b0;
`endif
  end

  // Credit check counts a same-cycle pop so a full-rate stream never bubbles.
  assign occ       = cnt + {1'b0, inflight};
  assign pop       = out_valid && out_ready;
  assign push      = inflight && (state == STREAM);
  assign hdr_issue = (state == HDR) && (hcnt < 3'd6);
  assign issue     = (state == STREAM) && !rd_done && ((occ - {1'b0, pop}) < 2'd2);

  assign RAM_rd_en   = hdr_issue || issue;
  assign RAM_rd_addr = hdr_issue ? ADDR_WIDTH'(hcnt) : (issue ? raddr : '0);
  assign out_valid   = (cnt != 2'd0);
  assign out_data    = out_valid ? fifo_data[rp] : '0;
  assign out_last    = out_valid && (byte_cnt == last_addr);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

  always_ff @(posedge clk) begin
    if (push) fifo_data[wp] <= RAM_Q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      dcnt      <= '0;
      size_lo   <= '0;
      raddr     <= '0;
      last_addr <= '0;
      byte_cnt  <= '0;
      rd_done   <= 1'b0;
      inflight  <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
`ifdef BMP_SIG_CHECK_EN
      sig0      <= '0;
      sig1      <= '0;
`endif
    end else begin
      inflight <= RAM_rd_en;
      case (state)
        IDLE: if (start) begin
          state <= HDR;
          err   <= 1'b0;
          hcnt  <= '0;
          dcnt  <= '0;
          wp    <= 1'b0;
          rp    <= 1'b0;
          cnt   <= '0;
        end
        HDR: begin
          if (hdr_issue) hcnt <= hcnt + 3'd1;
          if (inflight) begin
            dcnt <= dcnt + 3'd1;
            case (dcnt)
`ifdef BMP_SIG_CHECK_EN
              3'd0: sig0 <= RAM_Q[7:0];
              3'd1: sig1 <= RAM_Q[7:0];
`endif
              3'd2: size_lo[7:0]   <= RAM_Q[7:0];
              3'd3: size_lo[15:8]  <= RAM_Q[7:0];
              3'd4: size_lo[23:16] <= RAM_Q[7:0];
              3'd5: begin
                if (hdr_ok) begin
                  state     <= STREAM;
                  raddr     <= '0;
                  last_addr <= ADDR_WIDTH'(hdr_size - 32'd1);
                  byte_cnt  <= '0;
                  rd_done   <= 1'b0;
                end else begin
                  state <= FIN;
                  err   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        STREAM: begin
          if (issue) begin
            if (raddr == last_addr) rd_done <= 1'b1;
            else                    raddr   <= raddr + 1'b1;
          end
          if (push) wp <= ~wp;
          if (pop) begin
            rp       <= ~rp;
            byte_cnt <= byte_cnt + 1'b1;
            if (out_last) state <= FIN;
          end
          cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
